// File: rtl/ff_pkg.sv
// ff_pkg: shared defaults for the ff storage register
package ff_pkg;
  localparam int FF_DEFAULT_WIDTH = 1;
endpackage

// File: rtl/ff.sv
// ff: D register with clock enable and sync active-high reset; ports clock_enable, clk, d[WIDTH], q[WIDTH], reset
module ff
  import ff_pkg::*;
#(
  parameter int WIDTH = FF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock_enable,
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  input  logic             reset
);
  always_ff @(posedge clk) q <= reset ? RESET_VALUE : clock_enable ? d : q;
`ifndef SYNTHESIS
  logic [WIDTH-1:0] q_exp;
  logic [WIDTH-1:0] q_low;
  logic             was_reset;
  always_ff @(posedge clk) begin
    q_exp     <= reset ? RESET_VALUE : clock_enable ? d : q;
    was_reset <= reset;
  end
  always @(negedge clk) begin
    q_low <= q;
    assert (q === q_exp);
    if (was_reset) assert (q == RESET_VALUE);
  end
  always @(posedge clk) assert (q === q_low);
`endif
endmodule

// File: tb/tb_ff.sv
// tb_ff: self-checking bench for ff (1-bit and 8-bit instances)
module tb_ff;
  logic       clk = 1'b0;
  logic       reset1, ce1, d1, q1;
  logic       reset8, ce8;
  logic [7:0] d8, q8;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       m1, v1;
  logic [7:0] m8;
  logic       v8;

  ff #(.WIDTH(1)) u_ff1 (
    .clock_enable(ce1), .clk(clk), .d(d1), .q(q1), .reset(reset1)
  );
  ff #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_ff8 (
    .clock_enable(ce8), .clk(clk), .d(d8), .q(q8), .reset(reset8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rise;
    @(posedge clk);
    #1;
  endtask

  initial begin
    v1 = 1'b0;
    v8 = 1'b0;
  end

  always @(posedge clk) begin
    if (reset1 || ce1) begin
      m1 = reset1 ? 1'b0 : d1;
      v1 = 1'b1;
    end
    if (reset8 || ce8) begin
      m8 = reset8 ? 8'hA5 : d8;
      v8 = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (v1) chk("model_q1_post_rise", {7'b0, q1}, {7'b0, m1});
    if (v8) chk("model_q8_post_rise", q8, m8);
  end

  always @(negedge clk) begin
    if (v1) chk("model_q1_fall", {7'b0, q1}, {7'b0, m1});
    if (v8) chk("model_q8_fall", q8, m8);
  end

  initial begin
    reset1 = 1'b1; ce1 = 1'b0; d1 = 1'b0;
    reset8 = 1'b1; ce8 = 1'b0; d8 = 8'h00;
    rise;
    chk("reset_q1", {7'b0, q1}, 8'h00);
    chk("reset_q8", q8, 8'hA5);
    reset1 = 1'b0; reset8 = 1'b0;
    d1 = 1'b1; ce1 = 1'b1;
    rise;
    chk("load_enabled", {7'b0, q1}, 8'h01);
    d1 = 1'b0; #1;
    chk("hold_d_low_clk_high", {7'b0, q1}, 8'h01);
    d1 = 1'b1; #1;
    chk("hold_d_high_clk_high", {7'b0, q1}, 8'h01);
    d1 = 1'b0;
    @(negedge clk); #1;
    chk("hold_falling_edge", {7'b0, q1}, 8'h01);
    rise;
    chk("second_load_zero", {7'b0, q1}, 8'h00);
    d1 = 1'b1; #2;
    chk("second_load_wait", {7'b0, q1}, 8'h00);
    rise;
    chk("second_load_one", {7'b0, q1}, 8'h01);
    ce1 = 1'b0; d1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rise;
      chk("enable_low_hold", {7'b0, q1}, 8'h01);
    end
    ce1 = 1'b1;
    rise;
    chk("enable_restored", {7'b0, q1}, 8'h00);
    d1 = 1'b1;
    rise;
    chk("preload_for_reset", {7'b0, q1}, 8'h01);
    reset1 = 1'b1; #2;
    chk("reset_no_edge", {7'b0, q1}, 8'h01);
    rise;
    chk("reset_on_edge", {7'b0, q1}, 8'h00);
    d1 = 1'b1; ce1 = 1'b1;
    rise;
    chk("reset_priority", {7'b0, q1}, 8'h00);
    reset1 = 1'b0;
    rise;
    chk("first_load_after_reset", {7'b0, q1}, 8'h01);
    d8 = 8'h3C; ce8 = 1'b1;
    rise;
    chk("wide_load", q8, 8'h3C);
    d8 = 8'hFF; ce8 = 1'b0;
    rise;
    chk("wide_hold", q8, 8'h3C);
    d8 = 8'h5A; ce8 = 1'b1; reset8 = 1'b1;
    rise;
    chk("wide_reset_priority", q8, 8'hA5);
    reset8 = 1'b0;
    rise;
    chk("wide_load_after_reset", q8, 8'h5A);
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
